// File: rtl/noc_pkg.sv
// Shared NoC definitions: the packet type, the hop field location and the
// helper that applies the per-hop adjustment.
package noc_pkg;

  localparam int unsigned PKT_W   = 64;
  localparam int unsigned HOP_MSB = 55;
  localparam int unsigned HOP_LSB = 48;

  typedef logic [PKT_W-1:0] pkt_t;

  typedef enum logic {
    StEmpty,
    StFull
  } slot_state_e;

  // A zero hop means PE-bound; the packet passes untouched so the field never wraps.
  function automatic pkt_t hop_dec(pkt_t pkt);
    pkt_t res;
    res = pkt;
    if (pkt[HOP_MSB:HOP_LSB] != 8'd0) begin
      res[HOP_MSB:HOP_LSB] = pkt[HOP_MSB:HOP_LSB] - 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// Request/packet bundle from the input buffers plus the downstream valid/ready link.
interface output_port_arbiter_if #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned PKT_W  = 64
);
  localparam int unsigned PTR_W = $clog2(NUM_IN);

  logic [NUM_IN-1:0]       req;
  logic [NUM_IN*PKT_W-1:0] pkt_in;
  logic [NUM_IN-1:0]       gnt;
  logic                    out_valid;
  logic [PKT_W-1:0]        out_pkt;
  logic                    out_ready;
  logic [PTR_W-1:0]        prio_ptr;

  modport master (
    input  req, pkt_in, out_ready,
    output gnt, out_valid, out_pkt, prio_ptr
  );

  modport slave (
    output req, pkt_in, out_ready,
    input  gnt, out_valid, out_pkt, prio_ptr
  );
endinterface

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping
// modulo NUM_IN, reported both one-hot and as a binary index.
module rr_priority_select #(
  parameter int unsigned NUM_IN = 4,
  localparam int unsigned IDX_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] gnt_oh,
  output logic [IDX_W-1:0]  gnt_idx
);

  always_comb begin
    int unsigned w_idx;
    logic        w_found;
    gnt_oh  = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      w_idx = (32'(ptr) + k) % NUM_IN;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (!w_found && (i == w_idx) && req[i]) begin
          gnt_oh[i] = 1'b1;
          gnt_idx   = IDX_W'(i);
          w_found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Router output port: round-robin grant among input buffers into a one-deep
// output slot, hop field adjusted on capture, valid/ready toward the link.
module output_port_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned PKT_W  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  output_port_arbiter_if.master bus
);

  localparam int unsigned PTR_W = $clog2(NUM_IN);

  slot_state_e      r_state;
  slot_state_e      w_state_d;
  pkt_t             r_out_pkt;
  logic [PTR_W-1:0] r_prio_ptr;

  logic              w_free;
  logic [NUM_IN-1:0] w_req_eff;
  logic [NUM_IN-1:0] w_gnt_oh;
  logic [PTR_W-1:0]  w_gnt_idx;
  logic              w_grant;
  logic [PTR_W-1:0]  w_ptr_d;
  pkt_t              w_sel_pkt;

  // Draining and refilling on one edge gives one packet per cycle.
  assign w_free    = (r_state == StEmpty) || bus.out_ready;
  assign w_req_eff = (!reset && w_free) ? bus.req : '0;
  assign w_grant   = |w_gnt_oh;

  rr_priority_select #(
    .NUM_IN(NUM_IN)
  ) u_select (
    .req    (w_req_eff),
    .ptr    (r_prio_ptr),
    .gnt_oh (w_gnt_oh),
    .gnt_idx(w_gnt_idx)
  );

  always_comb begin
    w_sel_pkt = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (w_gnt_idx == PTR_W'(i)) begin
        w_sel_pkt = bus.pkt_in[i*PKT_W +: PKT_W];
      end
    end
  end

  always_comb begin
    w_ptr_d = (32'(w_gnt_idx) == NUM_IN - 1) ? '0 : w_gnt_idx + 1'b1;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StEmpty: if (w_grant) w_state_d = StFull;
      StFull:  if (bus.out_ready) w_state_d = w_grant ? StFull : StEmpty;
      default: w_state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StEmpty;
      r_out_pkt  <= '0;
      r_prio_ptr <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_grant) begin
        r_out_pkt  <= hop_dec(w_sel_pkt);
        r_prio_ptr <= w_ptr_d;
      end
    end
  end

  assign bus.gnt       = w_gnt_oh;
  assign bus.out_valid = (r_state == StFull);
  assign bus.out_pkt   = r_out_pkt;
  assign bus.prio_ptr  = r_prio_ptr;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed vector table, hop boundary sequence,
// then randomized traffic against a behavioural slot/round-robin model.
module tb_output_port_arbiter;

  localparam int unsigned N = 4;

  localparam logic [63:0] P0 = 64'hC003_1234_5678_9ABC;
  localparam logic [63:0] P1 = 64'hC101_1234_5678_9ABC;
  localparam logic [63:0] P2 = 64'hC205_1234_5678_9ABC;
  localparam logic [63:0] P3 = 64'hC3FF_1234_5678_9ABC;
  localparam logic [63:0] E0 = 64'hC002_1234_5678_9ABC;
  localparam logic [63:0] E1 = 64'hC100_1234_5678_9ABC;
  localparam logic [63:0] E2 = 64'hC204_1234_5678_9ABC;
  localparam logic [63:0] E3 = 64'hC3FE_1234_5678_9ABC;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        rdy;
    logic [3:0]  gnt;
    logic        valid;
    logic        chk_pkt;
    logic [63:0] pkt;
    logic [1:0]  ptr;
  } vec_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  vec_t vq[$];

  logic        m_valid;
  logic [63:0] m_pkt;
  int          m_ptr;

  output_port_arbiter_if #(.NUM_IN(N), .PKT_W(64)) bus ();

  output_port_arbiter #(
    .NUM_IN(N),
    .PKT_W (64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_hop(input logic [63:0] p);
    if (((p >> 48) & 64'hFF) != 64'd0) return p - (64'd1 << 48);
    return p;
  endfunction

  initial begin
    logic [7:0]  hops [3];
    logic [7:0]  hop_exp [3];
    logic [63:0] pin;
    logic [63:0] pexp;
    logic [3:0]  exp_gnt;
    int          win;

    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.req = '0;
    bus.out_ready = 1'b0;
    bus.pkt_in = {P3, P2, P1, P0};

    //            rst   req    rdy   gnt    vld  chk  pkt    ptr
    vq.push_back('{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 64'h0, 2'd0}); // reset x2
    vq.push_back('{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 64'h0, 2'd0});
    vq.push_back('{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 64'h0, 2'd0}); // idle
    vq.push_back('{1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 1'b1, E2,    2'd3}); // single req
    vq.push_back('{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 64'h0, 2'd3}); // drain
    vq.push_back('{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 1'b1, 64'h0, 2'd0}); // reset gates gnt
    vq.push_back('{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 1'b1, E0,    2'd1}); // round robin
    vq.push_back('{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 1'b1, E1,    2'd2});
    vq.push_back('{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 1'b1, E2,    2'd3});
    vq.push_back('{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 1'b1, E3,    2'd0});
    vq.push_back('{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 1'b1, E0,    2'd1});
    for (int i = 0; i < 5; i++)                                       // backpressure
      vq.push_back('{1'b0, 4'h3, 1'b0, 4'h0, 1'b1, 1'b1, E0,  2'd1});
    vq.push_back('{1'b0, 4'h3, 1'b1, 4'h2, 1'b1, 1'b1, E1,    2'd2}); // release
    vq.push_back('{1'b1, 4'h8, 1'b0, 4'h0, 1'b0, 1'b1, 64'h0, 2'd0}); // reset mid-transfer
    vq.push_back('{1'b0, 4'h8, 1'b0, 4'h8, 1'b1, 1'b1, E3,    2'd0});
    vq.push_back('{1'b0, 4'h6, 1'b1, 4'h2, 1'b1, 1'b1, E1,    2'd2});
    vq.push_back('{1'b0, 4'h1, 1'b1, 4'h1, 1'b1, 1'b1, E0,    2'd1}); // wraps past 2,3
    vq.push_back('{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 64'h0, 2'd1});

    foreach (vq[n]) begin
      @(negedge clk);
      reset = vq[n].rst;
      bus.req = vq[n].req;
      bus.out_ready = vq[n].rdy;
      #1;
      check($sformatf("row%0d gnt", n), 64'(bus.gnt), 64'(vq[n].gnt));
      @(posedge clk);
      #1;
      check($sformatf("row%0d out_valid", n), 64'(bus.out_valid), 64'(vq[n].valid));
      if (vq[n].chk_pkt) check($sformatf("row%0d out_pkt", n), bus.out_pkt, vq[n].pkt);
      check($sformatf("row%0d prio_ptr", n), 64'(bus.prio_ptr), 64'(vq[n].ptr));
    end

    // Hop boundaries: 00 passes unchanged, 01 -> 00, FF -> FE.
    hops[0] = 8'h00; hop_exp[0] = 8'h00;
    hops[1] = 8'h01; hop_exp[1] = 8'h00;
    hops[2] = 8'hFF; hop_exp[2] = 8'hFE;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      pin  = {8'h5A, hops[h], 48'hDEAD_BEEF_0123};
      pexp = {8'h5A, hop_exp[h], 48'hDEAD_BEEF_0123};
      bus.pkt_in[63:0] = pin;
      bus.req = 4'h1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("hop %h out_pkt", hops[h]), bus.out_pkt, pexp);
    end

    // Randomized traffic against the behavioural model; first cycle resets both.
    m_valid = 1'b0;
    m_pkt   = '0;
    m_ptr   = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      reset = (n == 0) || ($urandom_range(0, 31) == 0);
      bus.req = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < int'(N); i++) begin
        bus.pkt_in[i*64 +: 64] = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) bus.pkt_in[i*64 + 48 +: 8] = 8'($urandom_range(0, 1));
      end
      win = -1;
      if (!reset && (!m_valid || bus.out_ready)) begin
        for (int k = 0; k < int'(N); k++) begin
          if (win < 0 && bus.req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        end
      end
      exp_gnt = (win >= 0) ? 4'(1 << win) : 4'h0;
      #1;
      check($sformatf("rand%0d gnt", n), 64'(bus.gnt), 64'(exp_gnt));
      if (reset) begin
        m_valid = 1'b0;
        m_pkt   = '0;
        m_ptr   = 0;
      end else if (win >= 0) begin
        m_valid = 1'b1;
        m_pkt   = ref_hop(bus.pkt_in[win*64 +: 64]);
        m_ptr   = (win + 1) % N;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check($sformatf("rand%0d out_valid", n), 64'(bus.out_valid), 64'(m_valid));
      check($sformatf("rand%0d prio_ptr", n), 64'(bus.prio_ptr), 64'(m_ptr));
      if (m_valid) check($sformatf("rand%0d out_pkt", n), bus.out_pkt, m_pkt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_port_arbiter.md
# output_port_arbiter

Round-robin arbiter and output register for one router output port. It shares a single 64-bit output channel among `NUM_IN` input channel buffers. Each cycle it grants at most one requesting buffer and latches that buffer's packet into the output slot with the hop field decremented. It presents the packet to the downstream link with a valid/ready handshake. One instance sits at each router output (N/E/S/W/PE) between the input buffers and the link.

## Interface
Parameters:
- `NUM_IN`, default 4: number of input buffers competing for this port (2..8).
- `PKT_W`, default 64: packet width; the hop field sits at [55:48].

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `req`, input, `NUM_IN`: per-buffer request, high while that buffer holds a packet for this port.
- `pkt_in`, input, `NUM_IN*PKT_W`: packet of buffer i on bits [i*PKT_W +: PKT_W].
- `gnt`, output, `NUM_IN`: one-hot grant pulse. The granted buffer treats it as a pop and clears on the same edge.
- `out_valid`, output, 1: output slot holds a packet.
- `out_pkt`, output, `PKT_W`: registered output packet.
- `out_ready`, input, 1: downstream accepts `out_pkt` this cycle.
- `prio_ptr`, output, ceil(log2 `NUM_IN`): current highest-priority index, for debug.

## Operation
- Slot FSM has two states:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- Slot is free in a cycle iff the FSM is in EMPTY, or it is in FULL with `out_ready`=1 (drain).
- Arbitration:
  - Runs only when `reset`=0 and the slot is free.
  - Winner is the first i with `req[i]`=1, scanning `prio_ptr`, `prio_ptr`+1, … mod `NUM_IN`.
  - `gnt` is combinational in that cycle and is all-zero if nothing is granted.
- On an edge with a grant to i:
  - `out_pkt` ← `pkt_in[i]`, hop-adjusted.
  - FSM → FULL.
  - `prio_ptr` ← (i+1) mod `NUM_IN`.
- On an edge with a drain and no grant: FSM → EMPTY. `out_pkt` holds its value; it is don't-care.
- FULL with `out_ready`=0: no grant, and `out_pkt`, `out_valid` and `prio_ptr` stay unchanged.
- Simultaneous drain and grant: the slot is refilled on the same edge and `out_valid` stays 1. This gives back-to-back throughput of 1 packet/cycle.
- Hop adjustment:
  - Hop is [55:48], unsigned 8-bit.
  - If hop ≠ 0, output hop = hop−1.
  - If hop = 0, the packet is PE-bound and passes unmodified. Decrement never wraps to 0xFF.
  - All other bits are copied verbatim.
- `prio_ptr` changes only on a grant. A requester that drops `req` before being granted is simply skipped; nothing is latched for it.

## Timing
- Reset values, applied on the first edge with `reset`=1:
  - `out_valid`=0, `out_pkt`=0, `prio_ptr`=0, FSM=EMPTY.
  - `gnt` is forced to 0 whenever `reset`=1.
- Latency: `req` high in cycle t with the slot free → `gnt` high in t → `out_valid`/`out_pkt` valid from t+1.
- A packet leaves on the edge ending the cycle where `out_valid` & `out_ready`.
- Reset mid-operation discards any held packet. No grant is issued in the reset cycle, so input buffers keep their packets.
- `gnt` has at most one bit set, never asserts for a bit whose `req`=0, and never asserts while FULL with `out_ready`=0.
- Fairness: a continuously requesting buffer is granted within `NUM_IN` grants.

## Structure
- Shared package `noc_pkg` holds:
  - `PKT_W`=64, `HOP_MSB`=55, `HOP_LSB`=48.
  - A `pkt_t` 64-bit typedef.
  - Function `hop_dec(pkt_t)`, which performs the hop adjustment above.
- Sub-module `rr_priority_select`:
  - Purely combinational, parameterised by `NUM_IN`.
  - Inputs `req` and `ptr`; outputs one-hot `gnt_oh` and a binary `gnt_idx`.
- The top level holds the slot FSM, the `out_pkt` register, the pointer register and the packet mux.

## Test plan
- Reset, then idle: after `reset`=1 for 2 cycles, `out_valid`=0, `out_pkt`=0, `prio_ptr`=0, `gnt`=0.
- Single request: `req`=4'b0100 with packet 0x00_05_… (hop 5) and `out_ready`=1 → `gnt`=4'b0100 in the same cycle; next cycle `out_valid`=1 with hop=4 and the rest unchanged; `prio_ptr`=3.
- Round-robin: `req`=4'b1111 held with `out_ready`=1 → grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with `out_valid` held at 1 throughout.
- Backpressure: slot FULL and `out_ready`=0 for 5 cycles with `req`=4'b0011 → `gnt`=0 and `out_pkt` stable; raise `out_ready` → grant issues in the same cycle.
- Hop boundary: packet with hop 0x00 → forwarded unchanged; hop 0x01 → 0x00; hop 0xFF → 0xFE.
- Reset mid-transfer: slot FULL, assert `reset` with `req`=4'b1000 → no grant; next cycle `out_valid`=0 and `prio_ptr`=0; after release, index 3 is granted.
